adder: RTL and testbench
========================

// Module: adder
//
// PURPOSE
//   Registered WIDTH-bit binary adder with carry-in and carry-out.
//   - Computes {cout, sum} = a + b + cin and presents the result one clock later.
//   - WIDTH=1 gives a clocked full adder, the bit-level arithmetic primitive.
//   - Wider instances serve datapath blocks needing a single-cycle registered add.
//
// PARAMETERS
//   WIDTH   1   operand and sum width in bits; legal range 1..64
//
// PORTS
//   clk        input   1      rising-edge clock
//   rst_n      input   1      asynchronous active-low reset
//   in_valid   input   1      a, b and cin are valid this cycle
//   a          input   WIDTH  operand A, unsigned (two's complement when ovf is used)
//   b          input   WIDTH  operand B
//   cin        input   1      carry-in, weight 1
//   out_valid  output  1      sum, cout (and ovf) hold a fresh result
//   sum        output  WIDTH  low WIDTH bits of a+b+cin
//   cout       output  1      carry out of bit WIDTH-1
//   ovf        output  1      signed overflow; present only with ADDER_OVF_EN
//
// BEHAVIOUR
//   - Reset:
//     - rst_n low asynchronously clears out_valid, sum, cout and ovf to 0.
//     - Outputs stay 0 while rst_n is low.
//     - Release is sampled on clk rising edge; the first capture occurs on the first edge after release.
//   - Capture: on each clk rising edge with in_valid=1, register {cout,sum} = a + b + cin.
//     - Width: zero-extend a and b to WIDTH+1 bits; add cin at bit 0.
//     - sum takes bits [WIDTH-1:0]; cout takes bit WIDTH.
//   - Latency: exactly 1 cycle.
//     - out_valid is in_valid delayed one cycle.
//     - Back-to-back valid inputs give back-to-back valid outputs.
//     - Throughput is 1 add per cycle; there is no backpressure.
//   - Hold: in_valid=0 at an edge leaves sum/cout/ovf unchanged and drives out_valid to 0 next cycle.
//   - Wrap-around: results modulo 2^WIDTH appear on sum, and the excess appears on cout.
//     - Example, WIDTH=8: 8'hFF + 8'h00 + 1 gives sum=8'h00, cout=1.
//   - X/Z: inputs are not sampled while in_valid=0. No X may propagate to outputs after reset.
//   - Reset mid-stream: a result in flight is discarded and out_valid=0 immediately. No partial result survives.
//   - Logic structure:
//     - WIDTH=1: a single full-adder cell, sum = a^b^cin and cout = a&b | cin&(a^b).
//     - Wider: a ripple chain of such cells.
//     - The structure must be fully combinational between input and register; no latches.
//
// CONFIGURATION
//   ADDER_OVF_EN
//     - Defined: port ovf exists and is registered alongside sum.
//       - ovf = (a[W-1] == b[W-1]) && (sum_next[W-1] != a[W-1]).
//       - ovf resets to 0 and obeys the same hold/valid rules as sum.
//     - Undefined: port ovf is absent; no overflow logic is generated.
//
// TESTING
//   1. WIDTH=1, exhaustive: drive all 8 {a,b,cin} combos 000..111, one per cycle with in_valid=1.
//      Next cycle {cout,sum} must be 00,01,01,10,01,10,10,11 in order.
//   2. WIDTH=8 wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, out_valid=1 one cycle later.
//      a=8'h2A, b=8'h10, cin=1 -> sum=8'h3B, cout=0.
//   3. Hold: after case 2, set in_valid=0 and change a=8'h55.
//      sum must stay 8'h3B and out_valid must drop to 0 one cycle later.
//   4. Async reset: assert rst_n=0 mid-cycle while out_valid=1.
//      sum, cout and out_valid must be 0 before the next clk edge.
//      After release, the first valid input gives a result after 1 cycle.
//   5. ADDER_OVF_EN, WIDTH=8: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1, cout=0.
//      a=8'h80, b=8'h80 -> sum=8'h00, ovf=1, cout=1.
//      a=8'hFF, b=8'h01 -> ovf=0.
//   6. Streaming: feed 16 consecutive random operand sets.
//      Each result must match a+b+cin exactly one cycle later, with out_valid high for all 16 cycles.

Source files
------------

// File: rtl/adder.sv
// rtl/adder.sv - registered WIDTH-bit ripple-carry adder, 1-cycle latency
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Ripple chain of full-adder cells; carry[0] is the carry-in.
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i]   = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout_d = carry[WIDTH];
    end

    // Operands are only sampled with in_valid, so X on idle inputs never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Like-signed operands whose result flips sign have overflowed.
    always_comb begin
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - directed self-checking bench for adder (WIDTH=1 and WIDTH=8 instances)
// Overflow checks are compiled only when ADDER_OVF_EN is defined.
module tb_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       out_valid1;
    logic [0:0] sum1;
    logic       cout1;

    logic       in_valid8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       out_valid8;
    logic [7:0] sum8;
    logic       cout8;
`ifdef ADDER_OVF_EN
    logic       ovf1;
    logic       ovf8;
`endif

    int checks = 0;
    int errors = 0;

    adder #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .sum       (sum1),
        .cout      (cout1)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

    adder #(.WIDTH(8)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .sum       (sum8),
        .cout      (cout8)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] fa_exp [8];
    logic [8:0] exp9;
    logic [2:0] combo;

    initial begin
        fa_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n     = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid8", 64'(out_valid8), 64'd0);
        check("reset_sum8",   64'(sum8),       64'd0);
        check("reset_cout8",  64'(cout8),      64'd0);
        check("reset_valid1", 64'(out_valid1), 64'd0);
`ifdef ADDER_OVF_EN
        check("reset_ovf8",   64'(ovf8),       64'd0);
`endif

        @(negedge clk);
        rst_n = 1'b1;

        // Full-adder truth table, one combo per cycle
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            combo     = 3'(i);
            in_valid1 = 1'b1;
            a1        = combo[2];
            b1        = combo[1];
            cin1      = combo[0];
            edge_then_sample();
            check($sformatf("fa_%0d", i), 64'({cout1, sum1}), 64'(fa_exp[i]));
            check($sformatf("fa_valid_%0d", i), 64'(out_valid1), 64'd1);
        end
        @(negedge clk);
        in_valid1 = 1'b0;

        // WIDTH=8 wrap-around and carry-in
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        edge_then_sample();
        check("wrap_sum",   64'(sum8),       64'h00);
        check("wrap_cout",  64'(cout8),      64'd1);
        check("wrap_valid", 64'(out_valid8), 64'd1);
        check("idle_w1_valid", 64'(out_valid1), 64'd0);

        @(negedge clk);
        a8 = 8'h2A; b8 = 8'h10; cin8 = 1'b1;
        edge_then_sample();
        check("cin_sum",  64'(sum8),  64'h3B);
        check("cin_cout", 64'(cout8), 64'd0);

        // Hold: operands change while idle
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'h55;
        edge_then_sample();
        check("hold_sum",   64'(sum8),       64'h3B);
        check("hold_valid", 64'(out_valid8), 64'd0);
        edge_then_sample();
        check("hold_sum2",  64'(sum8),       64'h3B);

        // Async reset mid-cycle while a result is being presented
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1;
        edge_then_sample();
        check("pre_rst_sum",   64'(sum8),       64'h11);
        check("pre_rst_cout",  64'(cout8),      64'd1);
        check("pre_rst_valid", 64'(out_valid8), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_sum",   64'(sum8),       64'd0);
        check("rst_cout",  64'(cout8),      64'd0);
        check("rst_valid", 64'(out_valid8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1;
        edge_then_sample();
        check("post_rst_sum",   64'(sum8),       64'h31);
        check("post_rst_valid", 64'(out_valid8), 64'd1);

`ifdef ADDER_OVF_EN
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        edge_then_sample();
        check("ovf_pos_sum",  64'(sum8),  64'h80);
        check("ovf_pos_ovf",  64'(ovf8),  64'd1);
        check("ovf_pos_cout", 64'(cout8), 64'd0);
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        edge_then_sample();
        check("ovf_neg_sum",  64'(sum8),  64'h00);
        check("ovf_neg_ovf",  64'(ovf8),  64'd1);
        check("ovf_neg_cout", 64'(cout8), 64'd1);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        edge_then_sample();
        check("ovf_none", 64'(ovf8), 64'd0);
`endif

        // Back-to-back random stream
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid8 = 1'b1;
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
            edge_then_sample();
            check($sformatf("stream_sum_%0d", k),   64'(sum8),       64'(exp9[7:0]));
            check($sformatf("stream_cout_%0d", k),  64'(cout8),      64'(exp9[8]));
            check($sformatf("stream_valid_%0d", k), 64'(out_valid8), 64'd1);
`ifdef ADDER_OVF_EN
            check($sformatf("stream_ovf_%0d", k), 64'(ovf8),
                  64'((a8[7] == b8[7]) && (exp9[7] != a8[7])));
`endif
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        edge_then_sample();
        check("stream_end_valid", 64'(out_valid8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
